// File: rtl/bus_pkg.sv
// Shared definitions for the bus scheduler: command fields, register indices,
// FSM state encoding and the bus-control decode used by the top level.
package bus_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Register index 0 on the src field means the external data word.
  localparam logic [1:0] REG_EXT = 2'd0;
  localparam logic [1:0] REG_R1  = 2'd1;
  localparam logic [1:0] REG_R2  = 2'd2;
  localparam logic [1:0] REG_R3  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_STEP1,
    ST_STEP2,
    ST_STEP3
  } state_e;

  typedef struct packed {
    logic [1:0] opc;
    logic [1:0] src;
    logic [1:0] dst;
  } cmd_t;

  typedef struct packed {
    logic       done;
    logic       err;
    logic [2:0] rout;
    logic [2:0] rin;
    logic       ext;
  } ctl_t;

  function automatic logic cmd_illegal(cmd_t c);
    logic ill;
    ill = 1'b0;
    case (c.opc)
      OP_RSVD: ill = 1'b1;
      OP_MOVE: ill = (c.dst == REG_EXT) || (c.src == c.dst);
      OP_SWAP: ill = (c.src == REG_EXT) || (c.dst == REG_EXT) || (c.src == c.dst);
      default: ill = 1'b0;
    endcase
    return ill;
  endfunction

  // Register index -> enable bit; index 0 (external) selects no register.
  function automatic logic [2:0] reg_en(logic [1:0] r);
    logic [2:0] en;
    case (r)
      REG_R1:  en = 3'b001;
      REG_R2:  en = 3'b010;
      REG_R3:  en = 3'b100;
      default: en = 3'b000;
    endcase
    return en;
  endfunction

  // Temp register for a swap is the one register not named by src or dst.
  function automatic logic [1:0] temp_reg(cmd_t c);
    logic [2:0] t;
    t = 3'd6 - {1'b0, c.src} - {1'b0, c.dst};
    return t[1:0];
  endfunction

  function automatic ctl_t decode(state_e st, cmd_t c);
    ctl_t       o;
    logic [1:0] t;
    o = '0;
    t = temp_reg(c);
    case (st)
      ST_ACK: begin
        o.done = 1'b1;
        o.err  = cmd_illegal(c);
      end
      ST_STEP1: begin
        if (c.opc == OP_SWAP) begin
          o.rout = reg_en(c.dst);
          o.rin  = reg_en(t);
        end else begin
          o.rout = reg_en(c.src);
          o.ext  = (c.src == REG_EXT);
          o.rin  = reg_en(c.dst);
          o.done = 1'b1;
        end
      end
      ST_STEP2: begin
        o.rout = reg_en(c.src);
        o.rin  = reg_en(c.dst);
      end
      ST_STEP3: begin
        o.rout = reg_en(t);
        o.rin  = reg_en(c.src);
        o.done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bus_sched_if.sv
// Requester/bus-control bundle of the bus scheduler.
interface bus_sched_if;
  logic [1:0] req;
  logic [5:0] op0;
  logic [5:0] op1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] Rout;
  logic [2:0] Rin;
  logic       Extern;

  modport master (
    output req, op0, op1,
    input  gnt, busy, done, err, Rout, Rin, Extern
  );

  modport slave (
    input  req, op0, op1,
    output gnt, busy, done, err, Rout, Rin, Extern
  );
endinterface

// File: rtl/bus_sched_rr_arb2.sv
// Two-way round-robin choice: ptr names the requester favoured on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Single requester always wins; on a tie the favoured one wins.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/bus_sched.sv
// Bus scheduler: arbitrates two requesters and sequences register-transfer
// commands into tri-state bus enables. All outputs are registered.
module bus_sched
  import bus_pkg::*;
(
  input  logic        Clock,
  input  logic        reset,
  bus_sched_if.slave  bus
);

  state_e     state_q, state_d;
  cmd_t       op_q, op_d;
  logic       ptr_q, ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  ctl_t       ctl_q, ctl_d;
  logic [1:0] win;
  cmd_t       sel_op;

  rr_arb2 u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (win)
  );

  // Next-state logic; outputs are decoded from the next state so that the
  // registered enables line up with the state they belong to.
  always_comb begin
    sel_op  = win[1] ? cmd_t'(bus.op1) : cmd_t'(bus.op0);
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          op_d    = sel_op;
          gnt_d   = win;
          ptr_d   = win[0];
          state_d = (sel_op.opc == OP_NOP || cmd_illegal(sel_op)) ? ST_ACK : ST_STEP1;
        end
      end
      ST_ACK:   state_d = ST_IDLE;
      ST_STEP1: state_d = (op_q.opc == OP_SWAP) ? ST_STEP2 : ST_IDLE;
      ST_STEP2: state_d = ST_STEP3;
      ST_STEP3: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    ctl_d  = decode(state_d, op_d);
  end

  // State, latched command, pointer and output registers.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ptr_q   <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = ctl_q.done;
  assign bus.err    = ctl_q.err;
  assign bus.Rout   = ctl_q.rout;
  assign bus.Rin    = ctl_q.rin;
  assign bus.Extern = ctl_q.ext;

endmodule

// File: tb/tb_bus_sched.sv
// Scoreboard bench for bus_sched: each issued command pushes its expected
// per-cycle output words; a negedge monitor pops and compares them.
module tb_bus_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_sched_if bif ();

  bus_sched dut (
    .Clock (clk),
    .reset (rst),
    .bus   (bif)
  );

  typedef struct {
    string      tag;
    logic [11:0] w;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        mon_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word layout: {gnt[1:0], busy, done, err, Rout[2:0], Rin[2:0], Extern}
  function automatic logic [11:0] wd(logic [1:0] g, logic b, logic d, logic e,
                                     logic [2:0] ro, logic [2:0] ri, logic x);
    return {g, b, d, e, ro, ri, x};
  endfunction

  function automatic logic [2:0] en(int unsigned r);
    logic [2:0] one;
    one = 3'b001;
    if (r == 0) return 3'b000;
    return one << (r - 1);
  endfunction

  function automatic void push(string tag, logic [11:0] w);
    exp_t e;
    e.tag = tag;
    e.w   = w;
    sb.push_back(e);
  endfunction

  // Reference: expected cycles of one command, ending with its IDLE cycle.
  function automatic void push_cmd(string tag, int unsigned id, logic [5:0] op);
    int unsigned opc, s, d, t;
    logic        ill;
    logic [1:0]  g;
    opc = op[5:4];
    s   = op[3:2];
    d   = op[1:0];
    g   = (id == 1) ? 2'b10 : 2'b01;
    ill = (opc == 3) ||
          (opc == 1 && (d == 0 || s == d)) ||
          (opc == 2 && (s == 0 || d == 0 || s == d));
    if (opc == 0 || ill) begin
      push(tag, wd(g, 1'b1, 1'b1, ill, 3'b000, 3'b000, 1'b0));
    end else if (opc == 1) begin
      push(tag, wd(g, 1'b1, 1'b1, 1'b0, en(s), en(d), s == 0));
    end else begin
      t = 6 - s - d;
      push({tag, ".s1"}, wd(g,     1'b1, 1'b0, 1'b0, en(d), en(t), 1'b0));
      push({tag, ".s2"}, wd(2'b00, 1'b1, 1'b0, 1'b0, en(s), en(d), 1'b0));
      push({tag, ".s3"}, wd(2'b00, 1'b1, 1'b1, 1'b0, en(t), en(s), 1'b0));
    end
    push({tag, ".idle"}, '0);
  endfunction

  function automatic logic [11:0] obs();
    return {bif.gnt, bif.busy, bif.done, bif.err, bif.Rout, bif.Rin, bif.Extern};
  endfunction

  // Called at a negedge; returns at the negedge where the trailing IDLE cycle
  // is compared, so consecutive calls run back-to-back.
  task automatic run_cmd(input string tag, input int unsigned id, input logic [5:0] op);
    int unsigned n0, n;
    #1;
    n0 = sb.size();
    push_cmd(tag, id, op);
    n = sb.size() - n0;
    if (id == 1) bif.op1 = op; else bif.op0 = op;
    bif.req[id] = 1'b1;
    @(negedge clk);
    #1 bif.req[id] = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Per-cycle monitor: bus exclusivity always, scoreboard when expected.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus_excl", 32'($countones({bif.Rout, bif.Extern}) <= 1), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, 32'(obs()), 32'(e.w));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rop;
    int unsigned rid;
    bif.req = '0;
    bif.op0 = '0;
    bif.op1 = '0;

    // Reset: outputs zero while held and just after release.
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(obs()), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_after", 32'(obs()), 32'd0);
    mon_en = 1'b1;

    // Both requesting continuously: grants alternate, requester 0 first.
    #1;
    for (int unsigned k = 0; k < 4; k++) begin
      push(((k % 2) == 0) ? "rr.g0" : "rr.g1",
           ((k % 2) == 0) ? wd(2'b01, 1'b1, 1'b1, 1'b0, 3'b001, 3'b010, 1'b0)
                          : wd(2'b10, 1'b1, 1'b1, 1'b0, 3'b010, 3'b100, 1'b0));
      push("rr.idle", '0);
    end
    bif.op0 = 6'h16;
    bif.op1 = 6'h1B;
    bif.req = 2'b11;
    repeat (8) @(negedge clk);
    #1 bif.req = 2'b00;
    @(negedge clk);

    // Directed commands, back-to-back.
    run_cmd("move12",  0, 6'h16);
    run_cmd("swap12",  1, 6'h26);
    run_cmd("load3",   0, 6'h13);
    run_cmd("mv11_il", 0, 6'h15);
    run_cmd("load1",   0, 6'h11);
    run_cmd("nop",     1, 6'h00);
    run_cmd("rsvd",    1, 6'h36);
    run_cmd("swp0_il", 1, 6'h21);
    run_cmd("swap32",  0, 6'h2E);
    run_cmd("mvdst0",  1, 6'h18);

    // Random commands.
    for (int i = 0; i < 16; i++) begin
      rid = $urandom_range(0, 1);
      rop = 6'($urandom);
      run_cmd("rand", rid, rop);
    end

    // Request/op changes while busy are ignored; held request served after.
    #1;
    push_cmd("busy.swap", 1, 6'h26);
    bif.op1 = 6'h26;
    bif.req = 2'b10;
    @(negedge clk);
    #1;
    bif.req = 2'b01;
    bif.op1 = 6'h3F;
    bif.op0 = 6'h1B;
    push_cmd("busy.mv", 0, 6'h1B);
    repeat (4) @(negedge clk);
    #1 bif.req = 2'b00;
    @(negedge clk);

    // Reset during STEP2 of a swap from requester 0: abort, outputs cleared.
    #1;
    push("rst.s1", wd(2'b01, 1'b1, 1'b0, 1'b0, 3'b010, 3'b100, 1'b0));
    push("rst.s2", wd(2'b00, 1'b1, 1'b0, 1'b0, 3'b001, 3'b010, 1'b0));
    push("rst.hit", '0);
    push("rst.post", '0);
    push("rst.post2", '0);
    bif.op0 = 6'h26;
    bif.req = 2'b01;
    @(negedge clk);
    #1 bif.req = 2'b00;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pointer restored by reset: tie goes to requester 0 first.
    #1;
    push("ptr.g0", wd(2'b01, 1'b1, 1'b1, 1'b0, 3'b001, 3'b010, 1'b0));
    push("ptr.idle0", '0);
    push("ptr.g1", wd(2'b10, 1'b1, 1'b1, 1'b0, 3'b010, 3'b100, 1'b0));
    push("ptr.idle1", '0);
    bif.op0 = 6'h16;
    bif.op1 = 6'h1B;
    bif.req = 2'b11;
    @(negedge clk);
    #1 bif.req = 2'b10;
    repeat (2) @(negedge clk);
    #1 bif.req = 2'b00;
    repeat (2) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
